// File: rtl/seg7_ca_decoder_monitor.sv
// Common-anode 7-segment receive monitor: filters multiplexed segment/select lines and decodes each digit.
// Optional HEX_DECODE_EN macro also accepts the A..F glyphs (codes 4'hA..4'hF).
module seg7_ca_decoder_monitor #(
    parameter int unsigned DIGITS     = 1,
    parameter int unsigned STABLE_CNT = 4,
    localparam int unsigned IDX_W     = (DIGITS > 1) ? $clog2(DIGITS) : 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  sample_en,
    input  logic [6:0]            Segments,
    input  logic                  dp,
    input  logic [DIGITS-1:0]     SEL,
    output logic [4*DIGITS-1:0]   bcd_out,
    output logic [DIGITS-1:0]     dp_out,
    output logic [DIGITS-1:0]     digit_valid,
    output logic                  upd,
    output logic [IDX_W-1:0]      upd_idx,
    output logic                  pat_err,
    output logic                  sel_err
);

    localparam int unsigned SNAP_W = DIGITS + 8;
    localparam int unsigned CNT_W  = $clog2(STABLE_CNT + 1);
    localparam logic [6:0]  BLANK  = 7'h7F;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        TRACK = 2'd1,
        HOLD  = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [SNAP_W-1:0]     snap_q, snap_d;
    logic [4*DIGITS-1:0]   bcd_d;
    logic [DIGITS-1:0]     dp_out_d;
    logic [DIGITS-1:0]     valid_d;
    logic                  upd_d;
    logic [IDX_W-1:0]      upd_idx_d;
    logic                  pat_err_d;
    logic                  sel_err_d;

    logic [SNAP_W-1:0]     snap_c;
    logic                  sel_one_c;
    logic                  sel_none_c;
    logic [IDX_W-1:0]      sel_idx_c;
    logic [CNT_W-1:0]      cnt_inc_c;
    logic                  commit_c;
    logic [4:0]            glyph_c;

    // Active-low glyph to {legal, code}; blank is handled separately by the caller.
    function automatic logic [4:0] decode_glyph(input logic [6:0] seg);
        logic [4:0] res;
        res = 5'h00;
        case (seg)
            7'h40: res = {1'b1, 4'h0};
            7'h79: res = {1'b1, 4'h1};
            7'h24: res = {1'b1, 4'h2};
            7'h30: res = {1'b1, 4'h3};
            7'h19: res = {1'b1, 4'h4};
            7'h12: res = {1'b1, 4'h5};
            7'h02: res = {1'b1, 4'h6};
            7'h78: res = {1'b1, 4'h7};
            7'h00: res = {1'b1, 4'h8};
            7'h10: res = {1'b1, 4'h9};
`ifdef HEX_DECODE_EN
            7'h08: res = {1'b1, 4'hA};
            7'h03: res = {1'b1, 4'hB};
            7'h46: res = {1'b1, 4'hC};
            7'h21: res = {1'b1, 4'hD};
            7'h06: res = {1'b1, 4'hE};
            7'h0E: res = {1'b1, 4'hF};
`endif
            default: res = 5'h00;
        endcase
        return res;
    endfunction

    // Select-line classification and index of the single low bit.
    always_comb begin
        sel_idx_c  = '0;
        sel_one_c  = ($countones(~SEL) == 1);
        sel_none_c = (SEL == {DIGITS{1'b1}});
        for (int i = 0; i < DIGITS; i++) begin
            if (!SEL[i]) begin
                sel_idx_c = IDX_W'(i);
            end
        end
    end

    assign snap_c    = {SEL, Segments, dp};
    assign cnt_inc_c = (cnt_q == CNT_W'(STABLE_CNT)) ? cnt_q : cnt_q + CNT_W'(1);
    assign glyph_c   = decode_glyph(Segments);

    // Next-state, counter, snapshot and output update; evaluated only on sample ticks.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        snap_d    = snap_q;
        bcd_d     = bcd_out;
        dp_out_d  = dp_out;
        valid_d   = digit_valid;
        upd_d     = 1'b0;
        upd_idx_d = upd_idx;
        pat_err_d = 1'b0;
        sel_err_d = 1'b0;
        commit_c  = 1'b0;

        if (sample_en) begin
            snap_d = snap_c;
            case (state_q)
                IDLE: begin
                    if (sel_one_c) begin
                        state_d = TRACK;
                        cnt_d   = CNT_W'(1);
                    end else if (!sel_none_c) begin
                        sel_err_d = 1'b1;
                    end
                end
                TRACK, HOLD: begin
                    if (snap_c == snap_q) begin
                        if (state_q == TRACK) begin
                            cnt_d = cnt_inc_c;
                            if (cnt_inc_c == CNT_W'(STABLE_CNT)) begin
                                commit_c = 1'b1;
                                state_d  = HOLD;
                            end
                        end
                    end else if (sel_one_c) begin
                        state_d = TRACK;
                        cnt_d   = CNT_W'(1);
                    end else begin
                        state_d   = IDLE;
                        cnt_d     = '0;
                        sel_err_d = !sel_none_c;
                    end
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            endcase
        end

        // Only the digit named by the committed snapshot is written.
        if (commit_c) begin
            for (int i = 0; i < DIGITS; i++) begin
                if (IDX_W'(i) == sel_idx_c) begin
                    if (glyph_c[4]) begin
                        bcd_d[4*i +: 4] = glyph_c[3:0];
                        dp_out_d[i]     = ~dp;
                        valid_d[i]      = 1'b1;
                    end else if (Segments == BLANK) begin
                        dp_out_d[i]     = ~dp;
                        valid_d[i]      = 1'b0;
                    end else begin
                        valid_d[i]      = 1'b0;
                    end
                end
            end
            if (glyph_c[4]) begin
                upd_d     = 1'b1;
                upd_idx_d = sel_idx_c;
            end else if (Segments != BLANK) begin
                pat_err_d = 1'b1;
            end
        end
    end

    // State and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            snap_q      <= '0;
            bcd_out     <= '0;
            dp_out      <= '0;
            digit_valid <= '0;
            upd         <= 1'b0;
            upd_idx     <= '0;
            pat_err     <= 1'b0;
            sel_err     <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            snap_q      <= snap_d;
            bcd_out     <= bcd_d;
            dp_out      <= dp_out_d;
            digit_valid <= valid_d;
            upd         <= upd_d;
            upd_idx     <= upd_idx_d;
            pat_err     <= pat_err_d;
            sel_err     <= sel_err_d;
        end
    end

endmodule

// File: tb/tb_seg7_ca_decoder_monitor.sv
// Directed bench for seg7_ca_decoder_monitor: a 1-digit and a 2-digit instance, STABLE_CNT=4.
module tb_seg7_ca_decoder_monitor;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       sample_en = 1'b1;
    logic [6:0] seg = 7'h7F;
    logic       dp = 1'b1;
    logic       sel1 = 1'b1;
    logic [1:0] sel2 = 2'b11;

    logic [3:0] bcd1;
    logic       dpo1, val1, upd1, pat1, se1;
    logic [0:0] idx1;
    logic [7:0] bcd2;
    logic [1:0] dpo2, val2;
    logic       upd2, pat2, se2;
    logic [0:0] idx2;

    int vectors = 0;
    int miscompares = 0;

    seg7_ca_decoder_monitor #(.DIGITS(1), .STABLE_CNT(4)) dut1 (
        .clk(clk), .rst_n(rst_n), .sample_en(sample_en), .Segments(seg), .dp(dp), .SEL(sel1),
        .bcd_out(bcd1), .dp_out(dpo1), .digit_valid(val1), .upd(upd1), .upd_idx(idx1),
        .pat_err(pat1), .sel_err(se1)
    );

    seg7_ca_decoder_monitor #(.DIGITS(2), .STABLE_CNT(4)) dut2 (
        .clk(clk), .rst_n(rst_n), .sample_en(sample_en), .Segments(seg), .dp(dp), .SEL(sel2),
        .bcd_out(bcd2), .dp_out(dpo2), .digit_valid(val2), .upd(upd2), .upd_idx(idx2),
        .pat_err(pat2), .sel_err(se2)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        // Reset state
        #12;
        chk("rst_bcd", 32'(bcd1), 32'h0);
        chk("rst_valid", 32'(val1), 32'h0);
        chk("rst_dpo", 32'(dpo1), 32'h0);
        chk("rst_upd", 32'(upd1), 32'h0);
        chk("rst_pat", 32'(pat1), 32'h0);
        chk("rst_sel", 32'(se1), 32'h0);
        rst_n = 1'b1;

        // Digit 0 glyph: commit on the 4th tick only
        sel1 = 1'b0; seg = 7'h40; dp = 1'b1;
        tick(3);
        chk("zero_early_upd", 32'(upd1), 32'h0);
        tick(1);
        chk("zero_upd", 32'(upd1), 32'h1);
        chk("zero_bcd", 32'(bcd1), 32'h0);
        chk("zero_valid", 32'(val1), 32'h1);
        chk("zero_dpo", 32'(dpo1), 32'h0);
        chk("zero_idx", 32'(idx1), 32'h0);
        tick(1);
        chk("zero_pulse_end", 32'(upd1), 32'h0);
        tick(2);
        chk("zero_no_recommit", 32'(upd1), 32'h0);
        chk("zero_valid_hold", 32'(val1), 32'h1);

        // Short run of 5 must not commit; 9 with dp lit does
        seg = 7'h12;
        tick(3);
        chk("five_no_upd", 32'(upd1), 32'h0);
        chk("five_bcd", 32'(bcd1), 32'h0);
        seg = 7'h10; dp = 1'b0;
        tick(3);
        chk("nine_early", 32'(upd1), 32'h0);
        tick(1);
        chk("nine_upd", 32'(upd1), 32'h1);
        chk("nine_bcd", 32'(bcd1), 32'h9);
        chk("nine_dpo", 32'(dpo1), 32'h1);
        chk("nine_valid", 32'(val1), 32'h1);

        // Illegal pattern
        seg = 7'h7E;
        tick(4);
        chk("bad_pat", 32'(pat1), 32'h1);
        chk("bad_upd", 32'(upd1), 32'h0);
        chk("bad_valid", 32'(val1), 32'h0);
        chk("bad_bcd", 32'(bcd1), 32'h9);
        chk("bad_dpo", 32'(dpo1), 32'h1);
        tick(1);
        chk("bad_pulse_end", 32'(pat1), 32'h0);

        // Blank: no pulses, dp still follows
        seg = 7'h7F; dp = 1'b1;
        tick(4);
        chk("blank_upd", 32'(upd1), 32'h0);
        chk("blank_pat", 32'(pat1), 32'h0);
        chk("blank_dpo", 32'(dpo1), 32'h0);
        chk("blank_bcd", 32'(bcd1), 32'h9);
        chk("blank_valid", 32'(val1), 32'h0);

        // No digit selected: back to idle, nothing happens
        sel1 = 1'b1;
        tick(6);
        chk("idle_upd", 32'(upd1), 32'h0);
        chk("idle_sel_err", 32'(se1), 32'h0);

        // Hex glyph A
        sel1 = 1'b0; seg = 7'h08; dp = 1'b1;
        tick(4);
`ifdef HEX_DECODE_EN
        chk("hexa_upd", 32'(upd1), 32'h1);
        chk("hexa_bcd", 32'(bcd1), 32'hA);
        chk("hexa_pat", 32'(pat1), 32'h0);
        chk("hexa_valid", 32'(val1), 32'h1);
`else
        chk("hexa_upd", 32'(upd1), 32'h0);
        chk("hexa_bcd", 32'(bcd1), 32'h9);
        chk("hexa_pat", 32'(pat1), 32'h1);
        chk("hexa_valid", 32'(val1), 32'h0);
`endif

        // Reset mid-run clears immediately and discards the partial run
        seg = 7'h24;
        tick(2);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_bcd", 32'(bcd1), 32'h0);
        chk("mid_rst_valid", 32'(val1), 32'h0);
        chk("mid_rst_upd", 32'(upd1), 32'h0);
        chk("mid_rst_pat", 32'(pat1), 32'h0);
        tick(1);
        rst_n = 1'b1;
        tick(3);
        chk("post_rst_early", 32'(upd1), 32'h0);
        tick(1);
        chk("post_rst_upd", 32'(upd1), 32'h1);
        chk("post_rst_bcd", 32'(bcd1), 32'h2);
        chk("post_rst_valid", 32'(val1), 32'h1);

        // Two-digit instance
        sel2 = 2'b10; seg = 7'h79; dp = 1'b1;
        tick(4);
        chk("d2_upd0", 32'(upd2), 32'h1);
        chk("d2_idx0", 32'(idx2), 32'h0);
        chk("d2_bcd0", 32'(bcd2), 32'h01);
        chk("d2_valid0", 32'(val2), 32'h1);
        sel2 = 2'b01; seg = 7'h24; dp = 1'b0;
        tick(4);
        chk("d2_upd1", 32'(upd2), 32'h1);
        chk("d2_idx1", 32'(idx2), 32'h1);
        chk("d2_bcd1", 32'(bcd2), 32'h21);
        chk("d2_valid1", 32'(val2), 32'h3);
        chk("d2_dpo1", 32'(dpo2), 32'h2);

        sel2 = 2'b00;
        tick(1);
        chk("d2_sel_err", 32'(se2), 32'h1);
        chk("d2_sel_upd", 32'(upd2), 32'h0);
        tick(1);
        chk("d2_sel_err_idle", 32'(se2), 32'h1);
        sel2 = 2'b11;
        tick(1);
        chk("d2_sel_err_end", 32'(se2), 32'h0);

        // Fresh run needed after the idle excursion
        sel2 = 2'b10; seg = 7'h79; dp = 1'b1;
        tick(3);
        chk("d2_restart_early", 32'(upd2), 32'h0);
        tick(1);
        chk("d2_restart_upd", 32'(upd2), 32'h1);
        chk("d2_restart_idx", 32'(idx2), 32'h0);
        chk("d2_restart_bcd", 32'(bcd2), 32'h21);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
